// File: rtl/bootloader_pkg.sv
// rtl/bootloader_pkg.sv - shared opcodes, length width and sequencer state encoding
package bootloader_pkg;

    localparam logic [7:0] OP_BOOT = 8'h00;
    localparam logic [7:0] OP_XFER = 8'h01;
    localparam int         LEN_W   = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_LEN2,
        ST_LEN3,
        ST_SETUP,
        ST_WRITE,
        ST_READ,
        ST_HOLD,
        ST_ABORT,
        ST_BOOTED
    } state_t;

endpackage

// File: rtl/spi_bridge_seq.sv
// rtl/spi_bridge_seq.sv - UART command parser driving the flash SPI byte engine and chip-select
import bootloader_pkg::*;

module spi_bridge_seq #(
    parameter int CS_GUARD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_break,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       spi_start,
    output logic [7:0] spi_wdata,
    input  logic       spi_busy,
    input  logic       spi_done,
    input  logic [7:0] spi_rdata,
    output logic       spi_cs_n,
    output logic       boot,
    output logic       overrun,
    output logic       active
);

    localparam int            GW         = $clog2(CS_GUARD + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(CS_GUARD - 1);

    state_t             state;
    logic [LEN_W-1:0]   tx_len;
    logic [LEN_W-1:0]   rx_len;
    logic [GW-1:0]      guard_cnt;
    logic [7:0]         slot_data;
    logic               slot_valid;
    // An SPI byte has been launched and its spi_done has not come back yet;
    // covers the cycle(s) before the engine raises spi_busy.
    logic               inflight;

    logic               byte_ok;
    logic               break_hit;
    logic               write_fire;
    logic               read_fire;

    // Decode strobes: a break always beats a byte arriving in the same cycle.
    always_comb begin
        byte_ok    = rx_valid && !rx_break;
        break_hit  = rx_break && (state inside {ST_LEN0, ST_LEN1, ST_LEN2, ST_LEN3,
                                                ST_SETUP, ST_WRITE, ST_READ, ST_HOLD});
        write_fire = (state == ST_WRITE) && slot_valid && !spi_busy && !inflight;
        read_fire  = (state == ST_READ) && !tx_valid && !spi_busy && !inflight;
    end

    assign active = (state != ST_IDLE);

    // Command sequencer: header parsing, CS windowing, byte pumping and break recovery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tx_len     <= '0;
            rx_len     <= '0;
            guard_cnt  <= '0;
            slot_data  <= '0;
            slot_valid <= 1'b0;
            inflight   <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            spi_start  <= 1'b0;
            spi_wdata  <= '0;
            spi_cs_n   <= 1'b1;
            boot       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end
            if (spi_done) begin
                inflight <= 1'b0;
            end

            if (break_hit) begin
                slot_valid <= 1'b0;
                tx_len     <= '0;
                rx_len     <= '0;
                guard_cnt  <= '0;
                // A byte still on the wire must finish before CS may rise.
                if ((spi_busy || inflight) && !spi_done) begin
                    state <= ST_ABORT;
                end else begin
                    spi_cs_n <= 1'b1;
                    state    <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (byte_ok) begin
                            if (rx_data == OP_BOOT) begin
                                boot  <= 1'b1;
                                state <= ST_BOOTED;
                            end else if (rx_data == OP_XFER) begin
                                state <= ST_LEN0;
                            end
                        end
                    end

                    ST_LEN0: begin
                        if (byte_ok) begin
                            tx_len[7:0] <= rx_data;
                            state       <= ST_LEN1;
                        end
                    end

                    ST_LEN1: begin
                        if (byte_ok) begin
                            tx_len[15:8] <= rx_data;
                            state        <= ST_LEN2;
                        end
                    end

                    ST_LEN2: begin
                        if (byte_ok) begin
                            rx_len[7:0] <= rx_data;
                            state       <= ST_LEN3;
                        end
                    end

                    ST_LEN3: begin
                        if (byte_ok) begin
                            rx_len[15:8] <= rx_data;
                            if ((tx_len == '0) && ({rx_data, rx_len[7:0]} == 16'h0000)) begin
                                state <= ST_IDLE;
                            end else begin
                                spi_cs_n  <= 1'b0;
                                guard_cnt <= '0;
                                state     <= ST_SETUP;
                            end
                        end
                    end

                    ST_SETUP: begin
                        // The host may already be streaming payload during the guard time.
                        if (byte_ok && (tx_len != '0)) begin
                            if (slot_valid) begin
                                overrun <= 1'b1;
                            end else begin
                                slot_data  <= rx_data;
                                slot_valid <= 1'b1;
                            end
                        end
                        if (guard_cnt == GUARD_LAST) begin
                            guard_cnt <= '0;
                            state     <= (tx_len == '0) ? ST_READ : ST_WRITE;
                        end else begin
                            guard_cnt <= guard_cnt + GW'(1);
                        end
                    end

                    ST_WRITE: begin
                        if (write_fire) begin
                            spi_start <= 1'b1;
                            spi_wdata <= slot_data;
                            inflight  <= 1'b1;
                        end
                        // A byte landing in the same cycle the slot drains is accepted.
                        if (byte_ok) begin
                            if (slot_valid && !write_fire) begin
                                overrun <= 1'b1;
                            end else begin
                                slot_data  <= rx_data;
                                slot_valid <= 1'b1;
                            end
                        end else if (write_fire) begin
                            slot_valid <= 1'b0;
                        end
                        if (spi_done && (tx_len != '0)) begin
                            tx_len <= tx_len - LEN_W'(1);
                            if (tx_len == LEN_W'(1)) begin
                                slot_valid <= 1'b0;
                                guard_cnt  <= '0;
                                state      <= (rx_len == '0) ? ST_HOLD : ST_READ;
                            end
                        end
                    end

                    ST_READ: begin
                        if (read_fire) begin
                            spi_start <= 1'b1;
                            spi_wdata <= 8'h00;
                            inflight  <= 1'b1;
                        end
                        if (spi_done && (rx_len != '0)) begin
                            tx_data  <= spi_rdata;
                            tx_valid <= 1'b1;
                            rx_len   <= rx_len - LEN_W'(1);
                            if (rx_len == LEN_W'(1)) begin
                                guard_cnt <= '0;
                                state     <= ST_HOLD;
                            end
                        end
                    end

                    ST_HOLD: begin
                        if (guard_cnt == GUARD_LAST) begin
                            guard_cnt <= '0;
                            spi_cs_n  <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            guard_cnt <= guard_cnt + GW'(1);
                        end
                    end

                    ST_ABORT: begin
                        if (spi_done) begin
                            spi_cs_n <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end

                    ST_BOOTED: begin
                        spi_cs_n <= 1'b1;
                    end

                    default: begin
                        spi_cs_n <= 1'b1;
                        state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_bridge_seq.sv
// tb/tb_spi_bridge_seq.sv - directed scenarios for the UART-to-SPI command sequencer
module tb_spi_bridge_seq;

    localparam int SPI_CYC = 4;
    localparam int GAP     = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_break;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       spi_start;
    logic [7:0] spi_wdata;
    logic       spi_busy;
    logic       spi_done;
    logic [7:0] spi_rdata;
    logic       spi_cs_n;
    logic       boot;
    logic       overrun;
    logic       active;

    logic       busy_m = 1'b0;
    logic       force_busy;
    int         busy_cnt = 0;
    int         start_cnt = 0;
    int         done_cnt = 0;
    int         cs_falls = 0;
    int         bad_start = 0;
    int         uart_cnt = 0;
    logic       prev_cs = 1'b1;
    logic [7:0] mosi_log [256];
    int         win_log  [256];
    logic [7:0] uart_log [256];
    logic [7:0] resp_mem [256];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign spi_busy = busy_m | force_busy;

    spi_bridge_seq #(.CS_GUARD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_break  (rx_break),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .spi_start (spi_start),
        .spi_wdata (spi_wdata),
        .spi_busy  (spi_busy),
        .spi_done  (spi_done),
        .spi_rdata (spi_rdata),
        .spi_cs_n  (spi_cs_n),
        .boot      (boot),
        .overrun   (overrun),
        .active    (active)
    );

    // SPI engine model plus CS / UART monitors
    always @(posedge clk) begin
        spi_done <= 1'b0;
        prev_cs  <= spi_cs_n;
        if (prev_cs && !spi_cs_n) cs_falls <= cs_falls + 1;
        if (tx_valid && tx_ready) begin
            uart_log[uart_cnt & 255] <= tx_data;
            uart_cnt <= uart_cnt + 1;
        end
        if (spi_start) begin
            mosi_log[start_cnt & 255] <= spi_wdata;
            win_log[start_cnt & 255]  <= cs_falls;
            start_cnt <= start_cnt + 1;
            if (spi_cs_n) bad_start <= bad_start + 1;
            busy_cnt <= SPI_CYC;
            busy_m   <= 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                busy_m    <= 1'b0;
                spi_done  <= 1'b1;
                spi_rdata <= resp_mem[done_cnt & 255];
                done_cnt  <= done_cnt + 1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_id_cmd();
        send_byte(8'h01, GAP); send_byte(8'h02, GAP); send_byte(8'h00, GAP);
        send_byte(8'h05, GAP); send_byte(8'h00, GAP); send_byte(8'h9F, GAP);
        send_byte(8'h00, GAP);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        rx_break   = 1'b0;
        tx_ready   = 1'b1;
        force_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({spi_cs_n, tx_valid, spi_start, boot, overrun, active} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=100000", {spi_cs_n, tx_valid, spi_start, boot, overrun, active});
        end
        checks++;
        if ({tx_data, spi_wdata} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0000", {tx_data, spi_wdata});
        end
    endtask

    task automatic test_id_read(input string tag);
        logic [7:0] exp_m [7] = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] exp_u [5] = '{8'hEF, 8'h40, 8'h18, 8'h00, 8'h00};
        int s0 = start_cnt, u0 = uart_cnt, f0 = cs_falls, b0 = bad_start, d0 = done_cnt;
        resp_mem[(d0) & 255]     = 8'hFF;
        resp_mem[(d0 + 1) & 255] = 8'hFF;
        for (int i = 0; i < 5; i++) resp_mem[(d0 + 2 + i) & 255] = exp_u[i];
        send_id_cmd();
        for (int i = 0; i < 3000; i++) begin
            if ((uart_cnt - u0 >= 5) && spi_cs_n) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (start_cnt - s0 !== 7) begin
            failures++;
            $display("FAIL %s_starts got=%0d exp=7", tag, start_cnt - s0);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (mosi_log[(s0 + i) & 255] !== exp_m[i] || win_log[(s0 + i) & 255] !== f0 + 1) begin
                failures++;
                $display("FAIL %s_mosi%0d got=%h/w%0d exp=%h/w%0d", tag, i,
                         mosi_log[(s0 + i) & 255], win_log[(s0 + i) & 255], exp_m[i], f0 + 1);
            end
        end
        checks++;
        if (uart_cnt - u0 !== 5) begin
            failures++;
            $display("FAIL %s_uart_count got=%0d exp=5", tag, uart_cnt - u0);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (uart_log[(u0 + i) & 255] !== exp_u[i]) begin
                failures++;
                $display("FAIL %s_uart%0d got=%h exp=%h", tag, i, uart_log[(u0 + i) & 255], exp_u[i]);
            end
        end
        checks++;
        if (cs_falls - f0 !== 1 || bad_start - b0 !== 0) begin
            failures++;
            $display("FAIL %s_cs got=falls%0d/bad%0d exp=falls1/bad0", tag, cs_falls - f0, bad_start - b0);
        end
        checks++;
        if ({spi_cs_n, active} !== 2'b10) begin
            failures++;
            $display("FAIL %s_end got=%b exp=10", tag, {spi_cs_n, active});
        end
    endtask

    task automatic test_break_header();
        int s0 = start_cnt, f0 = cs_falls;
        send_byte(8'h01, GAP); send_byte(8'h02, GAP); send_byte(8'h00, GAP);
        rx_break = 1'b1;
        @(negedge clk);
        rx_break = 1'b0;
        checks++;
        if ({active, spi_cs_n} !== 2'b01) begin
            failures++;
            $display("FAIL brk_hdr_idle got=%b exp=01", {active, spi_cs_n});
        end
        // break coinciding with an OP_BOOT byte: the byte must be discarded
        rx_break = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_break = 1'b0;
        rx_valid = 1'b0;
        repeat (GAP) @(negedge clk);
        checks++;
        if ({boot, active, start_cnt - s0, cs_falls - f0} !== {2'b00, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL brk_hdr_quiet got=boot%b act%b st%0d cs%0d exp=0,0,0,0",
                     boot, active, start_cnt - s0, cs_falls - f0);
        end
        test_id_read("brk_id");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [15] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h06,
                                   8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'hD8, 8'h02, 8'h00, 8'h00};
        logic [7:0] exp_m [5] = '{8'h06, 8'hD8, 8'h02, 8'h00, 8'h00};
        int s0 = start_cnt, u0 = uart_cnt, f0 = cs_falls;
        for (int i = 0; i < 15; i++) send_byte(bytes[i], GAP);
        for (int i = 0; i < 1000; i++) begin
            if (!active) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (start_cnt - s0 !== 5 || cs_falls - f0 !== 2) begin
            failures++;
            $display("FAIL b2b_counts got=st%0d/cs%0d exp=st5/cs2", start_cnt - s0, cs_falls - f0);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mosi_log[(s0 + i) & 255] !== exp_m[i] ||
                win_log[(s0 + i) & 255] !== f0 + ((i == 0) ? 1 : 2)) begin
                failures++;
                $display("FAIL b2b_mosi%0d got=%h/w%0d exp=%h/w%0d", i, mosi_log[(s0 + i) & 255],
                         win_log[(s0 + i) & 255], exp_m[i], f0 + ((i == 0) ? 1 : 2));
            end
        end
        checks++;
        if (uart_cnt - u0 !== 0 || spi_cs_n !== 1'b1) begin
            failures++;
            $display("FAIL b2b_tail got=uart%0d/cs%b exp=uart0/cs1", uart_cnt - u0, spi_cs_n);
        end
    endtask

    task automatic test_read_backpressure();
        int s0 = start_cnt, u0 = uart_cnt, d0 = done_cnt;
        bit stable = 1'b1;
        resp_mem[d0 & 255] = 8'h5A;
        send_byte(8'h01, GAP); send_byte(8'h00, GAP); send_byte(8'h00, GAP);
        send_byte(8'h01, GAP); send_byte(8'h00, GAP);
        for (int i = 0; i < 500; i++) begin
            if (!active) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (start_cnt - s0 !== 1 || mosi_log[s0 & 255] !== 8'h00 || uart_cnt - u0 !== 1 ||
            uart_log[u0 & 255] !== 8'h5A) begin
            failures++;
            $display("FAIL rd1 got=st%0d/mosi%h/uart%0d/%h exp=st1/mosi00/uart1/5a",
                     start_cnt - s0, mosi_log[s0 & 255], uart_cnt - u0, uart_log[u0 & 255]);
        end
        s0 = start_cnt; u0 = uart_cnt; d0 = done_cnt;
        resp_mem[d0 & 255]       = 8'h11;
        resp_mem[(d0 + 1) & 255] = 8'h22;
        tx_ready = 1'b0;
        send_byte(8'h01, GAP); send_byte(8'h00, GAP); send_byte(8'h00, GAP);
        send_byte(8'h02, GAP); send_byte(8'h00, 0);
        for (int i = 0; i < 500; i++) begin
            if (tx_valid) break;
            @(negedge clk);
        end
        checks++;
        if (tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL rd_bp_timeout got=%b exp=1", tx_valid);
        end
        for (int i = 0; i < 50; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'h11 || start_cnt - s0 !== 1) stable = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (stable !== 1'b1) begin
            failures++;
            $display("FAIL rd_bp_hold got=data%h/st%0d exp=data11/st1", tx_data, start_cnt - s0);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ((uart_cnt - u0 >= 2) && !active) break;
            @(negedge clk);
        end
        checks++;
        if (uart_cnt - u0 !== 2 || uart_log[u0 & 255] !== 8'h11 || uart_log[(u0 + 1) & 255] !== 8'h22 ||
            start_cnt - s0 !== 2) begin
            failures++;
            $display("FAIL rd_bp_drain got=n%0d/%h/%h/st%0d exp=n2/11/22/st2", uart_cnt - u0,
                     uart_log[u0 & 255], uart_log[(u0 + 1) & 255], start_cnt - s0);
        end
    endtask

    task automatic test_zero_len();
        int f0 = cs_falls, s0 = start_cnt;
        send_byte(8'h01, GAP); send_byte(8'h00, GAP); send_byte(8'h00, GAP); send_byte(8'h00, GAP);
        checks++;
        if (active !== 1'b1) begin
            failures++;
            $display("FAIL zero_len3_active got=%b exp=1", active);
        end
        send_byte(8'h00, 0);
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL zero_after_len3 got=%b exp=0", active);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (cs_falls - f0 !== 0 || start_cnt - s0 !== 0) begin
            failures++;
            $display("FAIL zero_quiet got=cs%0d/st%0d exp=cs0/st0", cs_falls - f0, start_cnt - s0);
        end
    endtask

    task automatic test_break_busy();
        int u0 = uart_cnt, d0 = done_cnt;
        bit low = 1'b1;
        resp_mem[d0 & 255] = 8'hAA;
        send_byte(8'h01, GAP); send_byte(8'h00, GAP); send_byte(8'h00, GAP);
        send_byte(8'h01, GAP); send_byte(8'h00, 0);
        for (int i = 0; i < 200; i++) begin
            if (busy_m) break;
            @(negedge clk);
        end
        rx_break = 1'b1;
        @(negedge clk);
        rx_break = 1'b0;
        checks++;
        if ({spi_cs_n, active} !== 2'b01) begin
            failures++;
            $display("FAIL brk_busy_abort got=%b exp=01", {spi_cs_n, active});
        end
        for (int i = 0; i < 200; i++) begin
            if (done_cnt != d0) break;
            if (spi_cs_n !== 1'b0) low = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (low !== 1'b1 || done_cnt == d0) begin
            failures++;
            $display("FAIL brk_busy_cs_low got=low%b/done%0d exp=low1/done1", low, done_cnt - d0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_cs_n, active, tx_valid} !== 3'b100 || uart_cnt - u0 !== 0) begin
            failures++;
            $display("FAIL brk_busy_end got=%b/uart%0d exp=100/uart0", {spi_cs_n, active, tx_valid}, uart_cnt - u0);
        end
    endtask

    task automatic test_boot();
        int f0, s0;
        send_byte(8'h00, 0);
        checks++;
        if ({boot, active} !== 2'b11) begin
            failures++;
            $display("FAIL boot_rise got=%b exp=11", {boot, active});
        end
        f0 = cs_falls;
        s0 = start_cnt;
        send_id_cmd();
        repeat (20) @(negedge clk);
        checks++;
        if (cs_falls - f0 !== 0 || start_cnt - s0 !== 0 || {spi_cs_n, boot} !== 2'b11) begin
            failures++;
            $display("FAIL boot_terminal got=cs%0d/st%0d/%b exp=cs0/st0/11",
                     cs_falls - f0, start_cnt - s0, {spi_cs_n, boot});
        end
    endtask

    task automatic test_overrun();
        int s0;
        do_reset();
        s0 = start_cnt;
        force_busy = 1'b1;
        send_byte(8'h01, GAP); send_byte(8'h03, GAP); send_byte(8'h00, GAP);
        send_byte(8'h00, GAP); send_byte(8'h00, GAP);
        send_byte(8'hAA, 2);
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_first got=%b exp=0", overrun);
        end
        send_byte(8'hBB, 2);
        checks++;
        if (overrun !== 1'b1 || start_cnt - s0 !== 0) begin
            failures++;
            $display("FAIL ovr_second got=%b/st%0d exp=1/st0", overrun, start_cnt - s0);
        end
        force_busy = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_sticky got=%b exp=1", overrun);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) resp_mem[i] = 8'h00;
        test_reset();
        test_id_read("id");
        test_break_header();
        test_back_to_back();
        test_read_backpressure();
        test_zero_len();
        test_break_busy();
        test_boot();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
